// File: rtl/pipe_adder_arbiter.sv
// Round-robin front end that shares one LAT-stage stallable adder between two
// requesters, with a valid/ID shadow pipeline and back-pressure via add_stop.
module pipe_adder_arbiter #(
    parameter int W     = 8,
    parameter int LAT   = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req0_valid,
    input  logic [W-1:0]     req0_a,
    input  logic [W-1:0]     req0_b,
    input  logic             req0_cin,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [W-1:0]     req1_a,
    input  logic [W-1:0]     req1_b,
    input  logic             req1_cin,
    output logic             req1_ready,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_cin,
    output logic             add_stop,
    input  logic [W-1:0]     add_sum,
    input  logic             add_cout,
    output logic             res_valid,
    output logic             res_id,
    output logic [W-1:0]     res_sum,
    output logic             res_cout,
    input  logic             res_ready,
    output logic [CNT_W-1:0] in_flight
);

    logic [LAT-1:0] vld;
    logic [LAT-1:0] id;
    logic           rr_ptr;
    logic           grant0;
    logic           grant1;
    logic           issue;

    // The head result may only leave the adder when the consumer takes it.
    assign add_stop = vld[LAT-1] & ~res_ready;

    // NOTE: every output of a combinational block gets a default first, so no path leaves a latch.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!add_stop && !flush) begin
            if (req0_valid && req1_valid) begin
                grant0 = rr_ptr;
                grant1 = ~rr_ptr;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign issue      = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (grant0) begin
            add_a   = req0_a;
            add_b   = req0_b;
            add_cin = req0_cin;
        end else if (grant1) begin
            add_a   = req1_a;
            add_b   = req1_b;
            add_cin = req1_cin;
        end
    end

    // NOTE: nonblocking assignments so every shadow stage shifts from its pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld    <= '0;
            id     <= '0;
            rr_ptr <= 1'b1;
        end else if (flush) begin
            vld <= '0;
        end else if (!add_stop) begin
            vld <= {vld[LAT-2:0], issue};
            id  <= {id[LAT-2:0], grant1};
            if (issue) begin
                rr_ptr <= grant1;
            end
        end
    end

    assign res_valid = vld[LAT-1];
    assign res_id    = id[LAT-1];
    assign res_sum   = add_sum;
    assign res_cout  = add_cout;

    // Derived from vld directly so the count can never drift from the shadow pipe.
    always_comb begin
        in_flight = '0;
        for (int i = 0; i < LAT; i++) begin
            in_flight = in_flight + CNT_W'(vld[i]);
        end
    end

endmodule

// File: tb/tb_pipe_adder_arbiter.sv
// Directed bench for pipe_adder_arbiter with a behavioural 4-stage stallable adder
// standing in for the shared datapath.
module tb_pipe_adder_arbiter;

    localparam int W     = 8;
    localparam int LAT   = 4;
    localparam int CNT_W = 3;

    localparam logic [7:0] BP_A    [5] = '{8'hFF, 8'h01, 8'h7F, 8'h10, 8'h20};
    localparam logic [7:0] BP_B    [5] = '{8'h01, 8'h02, 8'h80, 8'h01, 8'h22};
    localparam logic       BP_CIN  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic [7:0] BP_SUM  [5] = '{8'h00, 8'h03, 8'h00, 8'h11, 8'h42};
    localparam logic       BP_COUT [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             req0_valid, req0_cin, req0_ready;
    logic [W-1:0]     req0_a, req0_b;
    logic             req1_valid, req1_cin, req1_ready;
    logic [W-1:0]     req1_a, req1_b;
    logic [W-1:0]     add_a, add_b, add_sum;
    logic             add_cin, add_stop, add_cout;
    logic             res_valid, res_id, res_cout, res_ready;
    logic [W-1:0]     res_sum;
    logic [CNT_W-1:0] in_flight;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_adder_arbiter #(.W(W), .LAT(LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_cin(req0_cin), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_cin(req1_cin), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_stop(add_stop),
        .add_sum(add_sum), .add_cout(add_cout),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum),
        .res_cout(res_cout), .res_ready(res_ready), .in_flight(in_flight)
    );

    // Behavioural shared adder: sum formed on entry, then delayed LAT stages, frozen by stop.
    logic [W:0] apipe [LAT];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) apipe[i] <= '0;
        end else if (!add_stop) begin
            apipe[0] <= {1'b0, add_a} + {1'b0, add_b} + 9'(add_cin);
            for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
        end
    end
    assign add_sum  = apipe[LAT-1][W-1:0];
    assign add_cout = apipe[LAT-1][W];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
        res_ready  = 1'b1;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL reset_res_id got=%b exp=0", res_id); end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL reset_in_flight got=%0d exp=0", in_flight); end
        checks++; if (add_stop !== 1'b0) begin failures++; $display("FAIL reset_add_stop got=%b exp=0", add_stop); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
        checks++; if ({add_a, add_b, add_cin} !== 17'h0) begin failures++; $display("FAIL reset_add_ops got=%h exp=0", {add_a, add_b, add_cin}); end
        checks++; if (res_sum !== 8'h00) begin failures++; $display("FAIL reset_res_sum got=%h exp=00", res_sum); end
    endtask

    task automatic test_single_op();
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h01; req0_cin = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL single_ready got=%b exp=1", req0_ready); end
        checks++; if ({add_a, add_b, add_cin} !== {8'h0F, 8'h01, 1'b1}) begin failures++; $display("FAIL single_add_ops got=%h exp=%h", {add_a, add_b, add_cin}, {8'h0F, 8'h01, 1'b1}); end
        step();
        req0_valid = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            #1;
            checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid edge=%0d got=%b exp=0", e, res_valid); end
            checks++; if (in_flight !== 3'd1) begin failures++; $display("FAIL single_in_flight edge=%0d got=%0d exp=1", e, in_flight); end
            step();
        end
        #1;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL single_valid_edge4 got=%b exp=1", res_valid); end
        checks++; if (res_id !== 1'b0) begin failures++; $display("FAIL single_id got=%b exp=0", res_id); end
        checks++; if (res_sum !== 8'h11) begin failures++; $display("FAIL single_sum got=%h exp=11", res_sum); end
        checks++; if (res_cout !== 1'b0) begin failures++; $display("FAIL single_cout got=%b exp=0", res_cout); end
        step();
        #1;
        checks++; if ({res_valid, in_flight} !== 4'b0000) begin failures++; $display("FAIL single_drain got=%b exp=0000", {res_valid, in_flight}); end
    endtask

    task automatic test_tie_alternation();
        logic       exp_id;
        logic [7:0] exp_sum;
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h10; req0_b = 8'h20; req0_cin = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h40; req1_b = 8'h05; req1_cin = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== ((c % 2 == 0) ? 2'b10 : 2'b01)) begin failures++; $display("FAIL tie_grant cycle=%0d got=%b exp=%b", c, {req0_ready, req1_ready}, (c % 2 == 0) ? 2'b10 : 2'b01); end
            checks++; if (in_flight !== 3'((c < 4) ? c : 4)) begin failures++; $display("FAIL tie_in_flight cycle=%0d got=%0d exp=%0d", c, in_flight, (c < 4) ? c : 4); end
            if (c >= 4) begin
                exp_id  = 1'((c - 4) % 2);
                exp_sum = exp_id ? 8'h46 : 8'h30;
                checks++; if ({res_valid, res_id} !== {1'b1, exp_id}) begin failures++; $display("FAIL tie_result cycle=%0d got=%b exp=%b", c, {res_valid, res_id}, {1'b1, exp_id}); end
                checks++; if ({res_cout, res_sum} !== {1'b0, exp_sum}) begin failures++; $display("FAIL tie_sum cycle=%0d got=%h exp=%h", c, {res_cout, res_sum}, {1'b0, exp_sum}); end
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_back_pressure();
        apply_reset();
        res_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_a = BP_A[c]; req0_b = BP_B[c]; req0_cin = BP_CIN[c];
            #1;
            checks++; if ({req0_ready, add_stop} !== 2'b10) begin failures++; $display("FAIL bp_fill cycle=%0d got=%b exp=10", c, {req0_ready, add_stop}); end
            step();
        end
        req0_a = BP_A[4]; req0_b = BP_B[4]; req0_cin = BP_CIN[4];
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++; if ({add_stop, req0_ready, req1_ready} !== 3'b100) begin failures++; $display("FAIL bp_stall stall=%0d got=%b exp=100", s, {add_stop, req0_ready, req1_ready}); end
            checks++; if ({res_valid, res_cout, res_sum} !== {2'b11, 8'h00}) begin failures++; $display("FAIL bp_hold stall=%0d got=%h exp=%h", s, {res_valid, res_cout, res_sum}, {2'b11, 8'h00}); end
            checks++; if (in_flight !== 3'd4) begin failures++; $display("FAIL bp_stall_count stall=%0d got=%0d exp=4", s, in_flight); end
            step();
        end
        res_ready = 1'b1;
        #1;
        checks++; if ({add_stop, req0_ready} !== 2'b01) begin failures++; $display("FAIL bp_release got=%b exp=01", {add_stop, req0_ready}); end
        checks++; if ({res_id, res_cout, res_sum} !== {2'b01, 8'h00}) begin failures++; $display("FAIL bp_first_result got=%h exp=%h", {res_id, res_cout, res_sum}, {2'b01, 8'h00}); end
        step();
        req0_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL bp_drain_valid k=%0d got=%b exp=1", k, res_valid); end
            checks++; if ({res_cout, res_sum} !== {BP_COUT[k], BP_SUM[k]}) begin failures++; $display("FAIL bp_drain_sum k=%0d got=%h exp=%h", k, {res_cout, res_sum}, {BP_COUT[k], BP_SUM[k]}); end
            checks++; if (in_flight !== 3'(5 - k)) begin failures++; $display("FAIL bp_drain_count k=%0d got=%0d exp=%0d", k, in_flight, 5 - k); end
            step();
        end
        #1;
        checks++; if ({res_valid, in_flight} !== 4'b0000) begin failures++; $display("FAIL bp_empty got=%b exp=0000", {res_valid, in_flight}); end
    endtask

    task automatic test_bubbles();
        logic       exp_v   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_i   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] exp_s   [5] = '{8'h44, 8'h00, 8'h00, 8'h03, 8'h00};
        apply_reset();
        req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h11; req1_cin = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL bubble_grant1 got=%b exp=01", {req0_ready, req1_ready}); end
        step();
        req1_valid = 1'b0;
        step();
        step();
        req0_valid = 1'b1; req0_a = 8'h01; req0_b = 8'h01; req0_cin = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL bubble_grant0 got=%b exp=10", {req0_ready, req1_ready}); end
        step();
        req0_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (res_valid !== exp_v[c]) begin failures++; $display("FAIL bubble_valid slot=%0d got=%b exp=%b", c, res_valid, exp_v[c]); end
            if (exp_v[c]) begin
                checks++; if ({res_id, res_sum} !== {exp_i[c], exp_s[c]}) begin failures++; $display("FAIL bubble_result slot=%0d got=%h exp=%h", c, {res_id, res_sum}, {exp_i[c], exp_s[c]}); end
            end
            if (c < 4) step();
        end
        checks++; if (in_flight !== 3'd0) begin failures++; $display("FAIL bubble_in_flight got=%0d exp=0", in_flight); end
    endtask

    task automatic test_flush();
        apply_reset();
        req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h06; req0_cin = 1'b0;
        step();
        step();
        step();
        req0_valid = 1'b0;
        #1;
        checks++; if (in_flight !== 3'd3) begin failures++; $display("FAIL flush_pre_count got=%0d exp=3", in_flight); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if ({res_valid, in_flight} !== 4'b0000) begin failures++; $display("FAIL flush_cleared cycle=%0d got=%b exp=0000", c, {res_valid, in_flight}); end
            step();
        end
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h01; req1_b = 8'h02;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin failures++; $display("FAIL flush_rr_kept got=%b exp=01", {req0_ready, req1_ready}); end
        idle_inputs();
        step();
    endtask

    task automatic test_async_reset();
        apply_reset();
        res_ready  = 1'b0;
        req1_valid = 1'b1; req1_a = 8'h21; req1_b = 8'h12;
        for (int c = 0; c < 4; c++) step();
        req1_valid = 1'b0;
        #1;
        checks++; if ({res_valid, add_stop, in_flight} !== {2'b11, 3'd4}) begin failures++; $display("FAIL async_pre got=%b exp=%b", {res_valid, add_stop, in_flight}, {2'b11, 3'd4}); end
        #2 rst = 1'b1;
        #1;
        checks++; if ({res_valid, add_stop, in_flight} !== 5'b00000) begin failures++; $display("FAIL async_clear got=%b exp=00000", {res_valid, add_stop, in_flight}); end
        #1 rst = 1'b0;
        res_ready  = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL async_rr_reset got=%b exp=10", {req0_ready, req1_ready}); end
        idle_inputs();
        step();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single_op();
        test_tie_alternation();
        test_back_pressure();
        test_bubbles();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
